// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: configurable serial pattern detector with arm/disarm control and saturating match counter
module seq_detect_ctrl #(
    parameter int MAXLEN  = 8,
    parameter int CNT_W   = 8,
    parameter int OVERLAP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [MAXLEN-1:0] cfg_pattern,
    input  logic [3:0]        cfg_len,
    output logic              cfg_err,
    input  logic              arm,
    input  logic              disarm,
    output logic              armed,
    output logic              z,
    input  logic              count_clr,
    output logic [CNT_W-1:0]  match_count
);

    typedef enum logic {IDLE, ARMED} state_t;

    state_t              state_q, state_d;
    logic [MAXLEN-2:0]   hist_q, hist_d;
    logic [3:0]          fill_q, fill_d;
    logic [MAXLEN-1:0]   pattern_q, pattern_d;
    logic [3:0]          len_q, len_d;
    logic                loaded_q, loaded_d;
    logic                z_q, z_d;
    logic                cfg_err_q, cfg_err_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic [MAXLEN-1:0]   shifted;
    logic [MAXLEN-1:0]   mask;
    logic                run, start, cfg_acc, cfg_ok, match;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state: arm needs a loaded pattern, disarm always wins
    always_comb begin
        state_d = (state_q == IDLE) ? ((arm && !disarm && loaded_q) ? ARMED : IDLE)
                                    : (disarm ? IDLE : ARMED);
    end

    // Moore outputs and registered pulses
    always_comb begin
        cfg_ready   = (state_q == IDLE);
        armed       = (state_q == ARMED);
        z           = z_q;
        cfg_err     = cfg_err_q;
        match_count = count_q;
    end

    // Datapath next values: history shift, fill tracking, match, config and counter
    always_comb begin
        shifted = {hist_q, w};
        mask    = '0;
        for (int i = 0; i < MAXLEN; i++) mask[i] = (i < int'(len_q));
        run       = (state_q == ARMED) && !disarm;
        start     = (state_q == IDLE) && (state_d == ARMED);
        cfg_acc   = cfg_valid && (state_q == IDLE);
        cfg_ok    = (cfg_len != 4'd0) && (cfg_len <= 4'(MAXLEN));
        match     = run && (({1'b0, fill_q} + 5'd1) >= {1'b0, len_q})
                        && (((shifted ^ pattern_q) & mask) == '0);
        hist_d    = start ? '0 : run ? shifted[MAXLEN-2:0] : hist_q;
        fill_d    = start ? 4'd0 : !run ? fill_q : (match && OVERLAP == 0) ? 4'd0
                  : (fill_q < len_q) ? fill_q + 4'd1 : fill_q;
        pattern_d = (cfg_acc && cfg_ok) ? cfg_pattern : pattern_q;
        len_d     = (cfg_acc && cfg_ok) ? cfg_len : len_q;
        loaded_d  = (cfg_acc && cfg_ok) ? 1'b1 : loaded_q;
        cfg_err_d = cfg_acc && !cfg_ok;
        z_d       = match;
        count_d   = match ? (count_clr ? CNT_W'(1) : (count_q == '1) ? count_q : count_q + CNT_W'(1))
                          : (count_clr ? '0 : count_q);
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q    <= '0;
            fill_q    <= '0;
            pattern_q <= '0;
            len_q     <= '0;
            loaded_q  <= 1'b0;
            z_q       <= 1'b0;
            cfg_err_q <= 1'b0;
            count_q   <= '0;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            loaded_q  <= loaded_d;
            z_q       <= z_d;
            cfg_err_q <= cfg_err_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: directed checks of seq_detect_ctrl in overlap, non-overlap and narrow-counter builds
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       rst, w, cfg_valid, arm, disarm, count_clr;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       rdy0, err0, armed0, z0;
    logic [7:0] cnt0;
    logic       rdy1, err1, armed1, z1;
    logic [7:0] cnt1;
    logic       rdy2, err2, armed2, z2;
    logic [1:0] cnt2;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [6:0] bits, ez0, ez1;

    always #5 clk = ~clk;

    seq_detect_ctrl #(.MAXLEN(8), .CNT_W(8), .OVERLAP(1)) u0 (
        .clk(clk), .rst(rst), .w(w), .cfg_valid(cfg_valid), .cfg_ready(rdy0),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_err(err0), .arm(arm),
        .disarm(disarm), .armed(armed0), .z(z0), .count_clr(count_clr), .match_count(cnt0));

    seq_detect_ctrl #(.MAXLEN(8), .CNT_W(8), .OVERLAP(0)) u1 (
        .clk(clk), .rst(rst), .w(w), .cfg_valid(cfg_valid), .cfg_ready(rdy1),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_err(err1), .arm(arm),
        .disarm(disarm), .armed(armed1), .z(z1), .count_clr(count_clr), .match_count(cnt1));

    seq_detect_ctrl #(.MAXLEN(8), .CNT_W(2), .OVERLAP(1)) u2 (
        .clk(clk), .rst(rst), .w(w), .cfg_valid(cfg_valid), .cfg_ready(rdy2),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_err(err2), .arm(arm),
        .disarm(disarm), .armed(armed2), .z(z2), .count_clr(count_clr), .match_count(cnt2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; w = 1'b0; cfg_valid = 1'b0; arm = 1'b0; disarm = 1'b0; count_clr = 1'b0;
        cfg_pattern = 8'h00; cfg_len = 4'd0;
        #1;
        chk("rst_ready", 32'(rdy0), 32'd1);
        chk("rst_armed", 32'(armed0), 32'd0);
        chk("rst_z", 32'(z0), 32'd0);
        chk("rst_err", 32'(err0), 32'd0);
        chk("rst_cnt", 32'(cnt0), 32'd0);
        tick(); tick();
        rst = 1'b0;
        // zero-length config is rejected and leaves the block unloaded
        cfg_valid = 1'b1; cfg_len = 4'd0; cfg_pattern = 8'hFF;
        tick();
        cfg_valid = 1'b0;
        chk("len0_err", 32'(err0), 32'd1);
        tick();
        chk("len0_err_clr", 32'(err0), 32'd0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("arm_unloaded", 32'(armed0), 32'd0);
        chk("ready_unloaded", 32'(rdy0), 32'd1);
        // load 1011 and arm
        cfg_valid = 1'b1; cfg_pattern = 8'b0000_1011; cfg_len = 4'd4;
        tick();
        cfg_valid = 1'b0;
        chk("cfg_ok_err", 32'(err0), 32'd0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("armed", 32'(armed0), 32'd1);
        chk("ready_armed", 32'(rdy0), 32'd0);
        // 1,0,1,1,0,1,1 : overlapping hits on bits 4 and 7, non-overlap only on bit 4
        bits = 7'b1011011; ez0 = 7'b0001001; ez1 = 7'b0001000;
        for (int i = 6; i >= 0; i--) begin
            w = bits[i];
            tick();
            chk("z_ovl", 32'(z0), 32'(ez0[i]));
            chk("z_novl", 32'(z1), 32'(ez1[i]));
        end
        chk("cnt_ovl", 32'(cnt0), 32'd2);
        chk("cnt_novl", 32'(cnt1), 32'd1);
        // disarm keeps count
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        chk("disarmed", 32'(armed0), 32'd0);
        chk("cnt_kept", 32'(cnt0), 32'd2);
        // over-long config rejected, old config retained
        cfg_valid = 1'b1; cfg_len = 4'd9; cfg_pattern = 8'h00;
        tick();
        cfg_valid = 1'b0;
        chk("len9_err", 32'(err0), 32'd1);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("rearmed", 32'(armed0), 32'd1);
        bits = 7'b0001011;
        for (int i = 3; i >= 0; i--) begin
            w = bits[i];
            tick();
            chk("z_retained", 32'(z0), (i == 0) ? 32'd1 : 32'd0);
        end
        chk("cnt_retained", 32'(cnt0), 32'd3);
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        // cfg_valid while armed is ignored silently
        cfg_valid = 1'b1; cfg_len = 4'd0; w = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("armed_cfg_noerr", 32'(err0), 32'd0);
        w = 1'b0; tick();
        w = 1'b1; tick();
        chk("z_partial", 32'(z0), 32'd0);
        // disarm on the final bit suppresses the match
        w = 1'b1; disarm = 1'b1;
        tick();
        disarm = 1'b0;
        chk("disarm_z", 32'(z0), 32'd0);
        chk("disarm_armed", 32'(armed0), 32'd0);
        chk("disarm_cnt", 32'(cnt0), 32'd3);
        // async reset mid-detection after 1,0,1
        arm = 1'b1;
        tick();
        arm = 1'b0;
        w = 1'b1; tick();
        w = 1'b0; tick();
        w = 1'b1; tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_armed", 32'(armed0), 32'd0);
        chk("arst_ready", 32'(rdy0), 32'd1);
        chk("arst_cnt", 32'(cnt0), 32'd0);
        chk("arst_z", 32'(z0), 32'd0);
        rst = 1'b0;
        cfg_valid = 1'b1; cfg_pattern = 8'b0000_1011; cfg_len = 4'd4;
        tick();
        cfg_valid = 1'b0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        w = 1'b1;
        tick();
        chk("post_rst_z", 32'(z0), 32'd0);
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        // pattern 11 len 2 with a 2-bit counter
        cfg_valid = 1'b1; cfg_pattern = 8'b0000_0011; cfg_len = 4'd2;
        tick();
        cfg_valid = 1'b0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            w = 1'b1;
            tick();
            chk("z_11", 32'(z2), (k == 1) ? 32'd0 : 32'd1);
            chk("cnt_sat", 32'(cnt2), (k - 1 > 3) ? 32'd3 : 32'(k - 1));
        end
        chk("cnt_wide", 32'(cnt0), 32'd5);
        // clear coinciding with a match leaves one
        count_clr = 1'b1; w = 1'b1;
        tick();
        chk("clr_match_cnt", 32'(cnt2), 32'd1);
        chk("clr_match_z", 32'(z2), 32'd1);
        w = 1'b0;
        tick();
        count_clr = 1'b0;
        chk("clr_cnt", 32'(cnt2), 32'd0);
        chk("clr_z", 32'(z2), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
